spi_ram_arbiter: RTL and testbench

Shares one single-port RAM between the SPI slave command stream and a local parallel requester. Decodes the SPI slave's 10-bit command words and keeps the write and read address latches. Arbitrates RAM cycles round-robin and returns read data to the SPI slave (tx path) or the local port. Sits between `spi_slave` and the RAM; the RAM itself has no decode logic.

---
 rtl/spi_ram_arbiter_pkg.sv | 24 ++
 rtl/spi_ram_arbiter_if.sv | 38 +++
 rtl/spi_ram_arbiter_rr_arb2.sv | 41 ++++
 rtl/spi_ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_arbiter_pkg.sv
// Shared constants and types for the SPI/local RAM arbiter:
// command opcodes, bus widths, FSM encoding and the pending-op record.
package spi_ram_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_op_t;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Bundle of SPI command/response, local requester and RAM signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface spi_ram_arbiter_if;
  import spi_ram_pkg::*;

  logic              spi_rx_valid;
  logic [9:0]        spi_rx_data;
  logic              spi_tx_valid;
  logic [DATA_W-1:0] spi_tx_data;
  logic              spi_ovf;

  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
  logic              loc_gnt;
  logic              loc_rvalid;
  logic [DATA_W-1:0] loc_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  spi_rx_valid, spi_rx_data, loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    output spi_tx_valid, spi_tx_data, spi_ovf, loc_gnt, loc_rvalid, loc_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output spi_rx_valid, spi_rx_data, loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    input  spi_tx_valid, spi_tx_data, spi_ovf, loc_gnt, loc_rvalid, loc_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. req[0] is SPI, req[1] is local;
// prio_q names the requester that wins a tie and flips only when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || !prio_q)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI command words into a one-entry pending slot and shares a single-port
// RAM between that slot and a local requester; read data returns two cycles after issue.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter bit AUTO_INC = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  spi_ram_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic              pend_q, pend_d;
  mem_op_t           pend_op_q, pend_op_d;
  logic              rd_tag_q, rd_tag_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              loc_rvalid_q, loc_rvalid_d;
  logic [DATA_W-1:0] loc_rdata_q, loc_rdata_d;
  logic              ovf_q, ovf_d;

  logic              arb_en;
  logic [1:0]        gnt;
  mem_op_t           loc_op, issue_op;
  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic              acc_op, acc_rd, spi_ret, loc_ret;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign opcode   = bus.spi_rx_data[9:8];
  assign payload  = bus.spi_rx_data[7:0];
  assign acc_op   = bus.spi_rx_valid && ((opcode == CMD_WR_DATA) || (opcode == CMD_RD_DATA));
  assign acc_rd   = bus.spi_rx_valid && (opcode == CMD_RD_DATA);
  assign loc_op   = {bus.loc_we, bus.loc_addr, bus.loc_wdata};
  assign issue_op = gnt[0] ? pend_op_q : loc_op;
  assign spi_ret  = (state_q == RD_WAIT) && !rd_tag_q;
  assign loc_ret  = (state_q == RD_WAIT) && rd_tag_q;

  // Grants only in IDLE and never while reset is asserted.
  assign arb_en = rst_n && (state_q == IDLE);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({bus.loc_req, pend_q}),
    .gnt   (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((|gnt) && !issue_op.we) state_d = RD_WAIT;
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_en) begin
      mem_we    = issue_op.we;
      mem_addr  = issue_op.addr;
      mem_wdata = issue_op.wdata;
    end
  end

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    pend_d       = pend_q && !gnt[0];
    pend_op_d    = pend_op_q;
    ovf_d        = ovf_q;
    rd_tag_d     = rd_tag_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    loc_rvalid_d = 1'b0;
    loc_rdata_d  = loc_rdata_q;

    if (bus.spi_rx_valid) begin
      case (opcode)
        CMD_WR_ADDR: wr_addr_d = payload;
        CMD_RD_ADDR: rd_addr_d = payload;
        CMD_WR_DATA: begin
          pend_op_d = {1'b1, wr_addr_q, payload};
          if (AUTO_INC) wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
        CMD_RD_DATA: begin
          pend_op_d = {1'b0, rd_addr_q, {DATA_W{1'b0}}};
          if (AUTO_INC) rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end

    // A slot that is issuing this cycle is free, so only a non-issuing hit overflows.
    if (acc_op) begin
      pend_d = 1'b1;
      if (pend_q && !gnt[0]) ovf_d = 1'b1;
    end

    if ((|gnt) && !issue_op.we) rd_tag_d = gnt[1];

    if (spi_ret) tx_data_d = bus.mem_rdata;
    if (spi_ret && !acc_rd) begin
      tx_valid_d = 1'b1;
    end else if (bus.spi_rx_valid) begin
      tx_valid_d = 1'b0;
    end

    if (loc_ret) begin
      loc_rvalid_d = 1'b1;
      loc_rdata_d  = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_q       <= 1'b0;
      pend_op_q    <= '0;
      ovf_q        <= 1'b0;
      rd_tag_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      loc_rvalid_q <= 1'b0;
      loc_rdata_q  <= '0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      pend_q       <= pend_d;
      pend_op_q    <= pend_op_d;
      ovf_q        <= ovf_d;
      rd_tag_q     <= rd_tag_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      loc_rvalid_q <= loc_rvalid_d;
      loc_rdata_q  <= loc_rdata_d;
    end
  end

  assign bus.mem_en       = mem_en;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.loc_gnt      = gnt[1];
  assign bus.loc_rvalid   = loc_rvalid_q;
  assign bus.loc_rdata    = loc_rdata_q;
  assign bus.spi_tx_valid = tx_valid_q;
  assign bus.spi_tx_data  = tx_data_q;
  assign bus.spi_ovf      = ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: one instance without and one with address
// auto-increment, each attached to a small behavioural RAM.
module tb_spi_ram_arbiter;

  logic clk;
  logic rst_n;
  logic preload;
  int   chk_cnt;
  int   err_cnt;

  logic [7:0] ram0 [0:255];
  logic [7:0] ram1 [0:255];

  spi_ram_arbiter_if bus0 ();
  spi_ram_arbiter_if bus1 ();

  spi_ram_arbiter #(.AUTO_INC(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_ram_arbiter #(.AUTO_INC(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (preload) begin
      ram0[8'h10] <= 8'h3C;
    end else if (bus0.mem_en) begin
      if (bus0.mem_we) ram0[bus0.mem_addr] <= bus0.mem_wdata;
      else             bus0.mem_rdata <= ram0[bus0.mem_addr];
    end
  end

  always @(posedge clk) begin
    if (bus1.mem_en) begin
      if (bus1.mem_we) ram1[bus1.mem_addr] <= bus1.mem_wdata;
      else             bus1.mem_rdata <= ram1[bus1.mem_addr];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic check_zero0(input string tag);
    check_val(tag, {bus0.spi_tx_valid, bus0.spi_tx_data, bus0.loc_gnt, bus0.loc_rvalid,
                    bus0.loc_rdata, bus0.mem_en, bus0.mem_we, bus0.mem_addr,
                    bus0.mem_wdata, bus0.spi_ovf}, 64'h0);
  endtask

  task automatic check_zero1(input string tag);
    check_val(tag, {bus1.spi_tx_valid, bus1.spi_tx_data, bus1.loc_gnt, bus1.loc_rvalid,
                    bus1.loc_rdata, bus1.mem_en, bus1.mem_we, bus1.mem_addr,
                    bus1.mem_wdata, bus1.spi_ovf}, 64'h0);
  endtask

  task automatic idle_inputs();
    bus0.spi_rx_valid = 1'b0; bus0.spi_rx_data = '0;
    bus0.loc_req = 1'b0; bus0.loc_we = 1'b0; bus0.loc_addr = '0; bus0.loc_wdata = '0;
    bus1.spi_rx_valid = 1'b0; bus1.spi_rx_data = '0;
    bus1.loc_req = 1'b0; bus1.loc_we = 1'b0; bus1.loc_addr = '0; bus1.loc_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    preload = 1'b1;
    rst_n   = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    preload = 1'b0;
    #1;
    check_zero0("reset_outs_dut0");
    check_zero1("reset_outs_dut1");

    // SPI write then SPI read of the same location
    @(negedge clk); bus0.spi_rx_valid = 1'b1; bus0.spi_rx_data = 10'h055;
    #1 check_val("a_addr_load_no_mem", bus0.mem_en, 1'b0);
    @(negedge clk); bus0.spi_rx_data = 10'h1A7;
    #1 check_val("a_accept_no_mem", bus0.mem_en, 1'b0);
    @(negedge clk); bus0.spi_rx_valid = 1'b0;
    #1 check_val("a_spi_write_issue", {bus0.loc_gnt, bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata},
                 {1'b0, 1'b1, 1'b1, 8'h55, 8'hA7});
    @(negedge clk); bus0.spi_rx_valid = 1'b1; bus0.spi_rx_data = 10'h255;
    #1 check_val("a_slot_cleared", bus0.mem_en, 1'b0);
    @(negedge clk); bus0.spi_rx_data = 10'h300;
    @(negedge clk); bus0.spi_rx_valid = 1'b0;
    #1 check_val("a_spi_read_issue", {bus0.mem_en, bus0.mem_we, bus0.mem_addr}, {1'b1, 1'b0, 8'h55});
    @(negedge clk);
    #1 check_val("a_rd_wait", {bus0.mem_en, bus0.spi_tx_valid}, 2'b00);
    @(negedge clk);
    #1 check_val("a_tx_data", {bus0.spi_tx_valid, bus0.spi_tx_data}, {1'b1, 8'hA7});

    // Local read; a local write request waiting in RD_WAIT must not be granted
    @(negedge clk); bus0.loc_req = 1'b1; bus0.loc_we = 1'b0; bus0.loc_addr = 8'h10;
    #1 check_val("b_loc_read_gnt", {bus0.loc_gnt, bus0.mem_en, bus0.mem_we, bus0.mem_addr},
                 {1'b1, 1'b1, 1'b0, 8'h10});
    @(negedge clk); bus0.loc_we = 1'b1; bus0.loc_addr = 8'h20; bus0.loc_wdata = 8'h99;
    #1 check_val("b_no_gnt_rd_wait", {bus0.loc_gnt, bus0.mem_en, bus0.loc_rvalid}, 3'b000);
    @(negedge clk);
    #1 check_val("b_loc_rdata", {bus0.loc_rvalid, bus0.loc_rdata}, {1'b1, 8'h3C});
    check_val("b_loc_write_gnt", {bus0.loc_gnt, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata},
              {1'b1, 1'b1, 8'h20, 8'h99});
    @(negedge clk); bus0.loc_req = 1'b0;
    #1 check_val("b_rvalid_pulse", bus0.loc_rvalid, 1'b0);
    check_val("b_tx_held", {bus0.spi_tx_valid, bus0.spi_tx_data}, {1'b1, 8'hA7});

    // Round-robin from reset with both requesters pending
    do_reset();
    @(negedge clk); bus0.spi_rx_valid = 1'b1; bus0.spi_rx_data = 10'h000;
    @(negedge clk); bus0.spi_rx_data = 10'h111;
    @(negedge clk); bus0.spi_rx_data = 10'h122;
    bus0.loc_req = 1'b1; bus0.loc_we = 1'b1; bus0.loc_addr = 8'h40; bus0.loc_wdata = 8'h77;
    #1 check_val("c_rr1_spi", {bus0.loc_gnt, bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata},
                 {1'b0, 1'b1, 1'b1, 8'h00, 8'h11});
    @(negedge clk); bus0.spi_rx_valid = 1'b0;
    #1 check_val("c_rr2_loc", {bus0.loc_gnt, bus0.mem_en, bus0.mem_addr, bus0.mem_wdata},
                 {1'b1, 1'b1, 8'h40, 8'h77});
    @(negedge clk); bus0.loc_addr = 8'h41; bus0.loc_wdata = 8'h78;
    #1 check_val("c_rr3_spi", {bus0.loc_gnt, bus0.mem_en, bus0.mem_addr, bus0.mem_wdata},
                 {1'b0, 1'b1, 8'h00, 8'h22});
    @(negedge clk);
    #1 check_val("c_rr4_loc", {bus0.loc_gnt, bus0.mem_addr, bus0.mem_wdata}, {1'b1, 8'h41, 8'h78});
    @(negedge clk); bus0.loc_req = 1'b0;
    #1 check_val("c_no_ovf_on_issue", {bus0.spi_ovf, bus0.mem_en}, 2'b00);

    // Two SPI writes without an issue between them while a local read waits
    @(negedge clk); bus0.spi_rx_valid = 1'b1; bus0.spi_rx_data = 10'h050;
    @(negedge clk); bus0.spi_rx_data = 10'h1AA;
    bus0.loc_req = 1'b1; bus0.loc_we = 1'b0; bus0.loc_addr = 8'h10;
    #1 check_val("d_loc_gnt", {bus0.loc_gnt, bus0.mem_en, bus0.mem_we, bus0.mem_addr},
                 {1'b1, 1'b1, 1'b0, 8'h10});
    @(negedge clk); bus0.spi_rx_data = 10'h1BB; bus0.loc_req = 1'b0;
    #1 check_val("d_rd_wait_idle", {bus0.mem_en, bus0.spi_ovf}, 2'b00);
    @(negedge clk); bus0.spi_rx_valid = 1'b0;
    #1 check_val("d_second_written", {bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata},
                 {1'b1, 1'b1, 8'h50, 8'hBB});
    check_val("d_ovf_set", bus0.spi_ovf, 1'b1);
    check_val("d_loc_rdata", {bus0.loc_rvalid, bus0.loc_rdata}, {1'b1, 8'h3C});
    repeat (3) @(negedge clk);
    #1 check_val("d_ovf_sticky", bus0.spi_ovf, 1'b1);
    check_val("d_ram_content", ram0[8'h50], 8'hBB);
    do_reset();
    #1 check_zero0("d_ovf_cleared_by_reset");

    // Auto-increment wrap on the second instance
    @(negedge clk); bus1.spi_rx_valid = 1'b1; bus1.spi_rx_data = 10'h0FF;
    @(negedge clk); bus1.spi_rx_data = 10'h1C1;
    @(negedge clk); bus1.spi_rx_data = 10'h1C2;
    #1 check_val("e_inc_first", {bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata},
                 {1'b1, 1'b1, 8'hFF, 8'hC1});
    @(negedge clk); bus1.spi_rx_valid = 1'b0;
    #1 check_val("e_inc_wrap", {bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata},
                 {1'b1, 1'b1, 8'h00, 8'hC2});
    check_val("e_no_ovf", bus1.spi_ovf, 1'b0);

    // SPI read of address 0, then reset in the middle of a local read
    @(negedge clk); bus0.spi_rx_valid = 1'b1; bus0.spi_rx_data = 10'h200;
    @(negedge clk); bus0.spi_rx_data = 10'h300;
    @(negedge clk); bus0.spi_rx_valid = 1'b0;
    #1 check_val("f_spi_read_issue", {bus0.mem_en, bus0.mem_we, bus0.mem_addr}, {1'b1, 1'b0, 8'h00});
    @(negedge clk);
    @(negedge clk);
    #1 check_val("f_tx_data", {bus0.spi_tx_valid, bus0.spi_tx_data}, {1'b1, 8'h22});
    @(negedge clk); bus0.loc_req = 1'b1; bus0.loc_we = 1'b0; bus0.loc_addr = 8'h10;
    #1 check_val("f_loc_gnt", bus0.loc_gnt, 1'b1);
    @(negedge clk); bus0.loc_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    #1 check_zero0("f_outs_after_reset");
    @(negedge clk); rst_n = 1'b1;
    #1 check_zero0("f_no_rvalid_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
